pe_array_mc: RTL and testbench

- Parametrised successor of the single-channel parallel PE.
- Computes CH independent dot-product accumulations per beat. One shared neuron vector is multiplied lane-wise against CH weight vectors, products are reduced, and results are accumulated across a ctl-delimited group of beats.
- Adds signed/unsigned mode, optional saturation, an output FIFO with valid/ready backpressure and protocol-error detection.
- Sits between the neuron/weight SRAM readers and the result writeback unit.

---
 rtl/pe_pkg.sv | 55 +++++
 rtl/pe_chan_mac.sv | 94 +++++++++
 rtl/sync_fifo.sv | 66 ++++++
 rtl/pe_array_mc.sv | 142 ++++++++++++++
 tb/tb_pe_array_mc.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pe_pkg
// Brief    : Shared widths, control bit indices and result conversion for the
//            multi-channel PE array.
// Revision : 1.0
// ============================================================================
package pe_pkg;

    localparam int CTL_FIRST = 0;
    localparam int CTL_LAST  = 1;

    // Working width for result conversion; must exceed the internal accumulator.
    localparam int CONV_W    = 128;

    function automatic int sum_width(input int dw, input int lanes);
        return 2 * dw + $clog2(lanes);
    endfunction

    function automatic int acc_int_width(input int acc_w);
        return acc_w + 8;
    endfunction

    // Caller extends val according to is_signed; only the low acc_w bits matter.
    function automatic logic [CONV_W-1:0] sat_trunc(
        input logic [CONV_W-1:0] val,
        input int                acc_w,
        input logic              is_signed,
        input logic              sat
    );
        logic signed [CONV_W-1:0] v;
        logic signed [CONV_W-1:0] one;
        logic signed [CONV_W-1:0] max_v;
        logic signed [CONV_W-1:0] min_v;
        v   = val;
        one = CONV_W'(1);
        if (is_signed) begin
            max_v = (one <<< (acc_w - 1)) - one;
            min_v = -max_v - one;
        end else begin
            max_v = (one <<< acc_w) - one;
            min_v = '0;
        end
        if (!sat)
            return val;
        else if (v > max_v)
            return max_v;
        else if (v < min_v)
            return min_v;
        else
            return val;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pe_chan_mac.sv
`default_nettype none
// ============================================================================
// Module   : pe_chan_mac
// Brief    : One channel: registered lane products, reduction, group accumulator.
// Revision : 1.0
// ============================================================================
module pe_chan_mac
    import pe_pkg::*;
#(
    parameter int LANES = 32,
    parameter int DW    = 16,
    parameter int ACC_W = 32
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              i_vld,
    input  logic                              i_first,
    input  logic                              i_sgn,
    input  logic [LANES*DW-1:0]               i_neuron,
    input  logic [LANES*DW-1:0]               i_weight,
    output logic [acc_int_width(ACC_W)-1:0]   o_acc
);

    localparam int c_sum_w = sum_width(DW, LANES);
    localparam int c_aiw   = acc_int_width(ACC_W);

    logic [2*DW-1:0]    w_prod [LANES];
    logic [2*DW-1:0]    r_prod [LANES];
    logic               r_vld1;
    logic               r_first1;
    logic               r_sgn1;
    logic [c_sum_w-1:0] w_sum;
    logic [c_sum_w-1:0] r_sum;
    logic               r_vld2;
    logic               r_first2;
    logic               r_sgn2;
    logic [c_aiw-1:0]   w_sum_ext;
    logic [c_aiw-1:0]   r_acc;

    // Operands widened to 2*DW so the low half of the product is exact in both modes.
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        logic [DW-1:0]   w_a;
        logic [DW-1:0]   w_b;
        logic [2*DW-1:0] w_a_ext;
        logic [2*DW-1:0] w_b_ext;
        assign w_a       = i_neuron[i*DW +: DW];
        assign w_b       = i_weight[i*DW +: DW];
        assign w_a_ext   = {{DW{i_sgn & w_a[DW-1]}}, w_a};
        assign w_b_ext   = {{DW{i_sgn & w_b[DW-1]}}, w_b};
        assign w_prod[i] = w_a_ext * w_b_ext;
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < LANES; i++)
            w_sum = w_sum + {{(c_sum_w-2*DW){r_sgn1 & r_prod[i][2*DW-1]}}, r_prod[i]};
    end

    assign w_sum_ext = {{(c_aiw-c_sum_w){r_sgn2 & r_sum[c_sum_w-1]}}, r_sum};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LANES; i++)
                r_prod[i] <= '0;
            r_vld1   <= 1'b0;
            r_first1 <= 1'b0;
            r_sgn1   <= 1'b0;
            r_sum    <= '0;
            r_vld2   <= 1'b0;
            r_first2 <= 1'b0;
            r_sgn2   <= 1'b0;
            r_acc    <= '0;
        end else begin
            r_vld1   <= i_vld;
            r_first1 <= i_first;
            r_sgn1   <= i_sgn;
            if (i_vld) begin
                for (int i = 0; i < LANES; i++)
                    r_prod[i] <= w_prod[i];
            end
            r_vld2   <= r_vld1;
            r_first2 <= r_first1;
            r_sgn2   <= r_sgn1;
            if (r_vld1)
                r_sum <= w_sum;
            if (r_vld2)
                r_acc <= r_first2 ? w_sum_ext : r_acc + w_sum_ext;
        end
    end

    assign o_acc = r_acc;

endmodule
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : sync_fifo
// Brief    : Show-ahead synchronous FIFO; output holds the last popped word when empty.
// Revision : 1.0
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [WIDTH-1:0]         i_din,
    input  logic                     i_pop,
    output logic [WIDTH-1:0]         o_dout,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int             c_aw   = $clog2(DEPTH);
    localparam logic [c_aw:0]  c_full = (c_aw+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_aw-1:0]  r_wr;
    logic [c_aw-1:0]  r_rd;
    logic [c_aw:0]    r_cnt;
    logic [WIDTH-1:0] r_hold;
    logic             w_pop;
    logic             w_push;

    assign w_pop  = i_pop & (r_cnt != '0);
    assign w_push = i_push & ((r_cnt != c_full) | w_pop);

    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr   <= '0;
            r_rd   <= '0;
            r_cnt  <= '0;
            r_hold <= '0;
        end else begin
            if (w_push)
                r_wr <= r_wr + 1'b1;
            if (w_pop) begin
                r_rd   <= r_rd + 1'b1;
                r_hold <= r_mem[r_rd];
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign o_empty = (r_cnt == '0);
    assign o_dout  = o_empty ? r_hold : r_mem[r_rd];
    assign o_count = r_cnt;

endmodule
`default_nettype wire

// File: rtl/pe_array_mc.sv
`default_nettype none
// ============================================================================
// Module   : pe_array_mc
// Brief    : CH-channel dot-product accumulator with group tracking, credit-based
//            backpressure, result conversion and output FIFO.
// Revision : 1.0
// ============================================================================
module pe_array_mc
    import pe_pkg::*;
#(
    parameter int LANES     = 32,
    parameter int DW        = 16,
    parameter int ACC_W     = 32,
    parameter int CH        = 4,
    parameter int OUT_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [LANES*DW-1:0]      neuron,
    input  logic [CH*LANES*DW-1:0]   weight,
    input  logic [1:0]               ctl,
    input  logic                     signed_en,
    input  logic                     sat_en,
    input  logic                     vld_i,
    output logic                     rdy_o,
    output logic [CH*ACC_W-1:0]      result,
    output logic                     vld_o,
    input  logic                     rdy_i,
    output logic                     err
);

    localparam int              c_aiw   = acc_int_width(ACC_W);
    localparam int              c_cw    = $clog2(OUT_DEPTH) + 1;
    localparam logic [c_cw:0]   c_depth = (c_cw+1)'(OUT_DEPTH);

    logic                 w_accept;
    logic                 w_first;
    logic                 w_last;
    logic                 w_beat_vld;
    logic                 w_beat_sgn;
    logic                 w_beat_sat;
    logic                 r_group_open;
    logic                 r_grp_sgn;
    logic                 r_grp_sat;
    logic                 r_err;
    logic [2:0]           r_push_pipe;
    logic [2:0]           r_sgn_pipe;
    logic [2:0]           r_sat_pipe;
    logic [1:0]           w_pending;
    logic [c_cw-1:0]      w_fifo_count;
    logic [c_cw:0]        w_used;
    logic                 w_fifo_empty;
    logic [CH*ACC_W-1:0]  w_fifo_din;
    logic [c_aiw-1:0]     w_acc [CH];

    assign w_accept   = vld_i & rdy_o;
    assign w_first    = ctl[CTL_FIRST];
    assign w_last     = ctl[CTL_LAST];
    // A non-first beat with no open group never enters the datapath.
    assign w_beat_vld = w_accept & (w_first | r_group_open);
    assign w_beat_sgn = w_first ? signed_en : r_grp_sgn;
    assign w_beat_sat = w_first ? sat_en    : r_grp_sat;

    // Every group close in flight reserves a FIFO slot until it is pushed.
    assign w_pending = {1'b0, r_push_pipe[0]} + {1'b0, r_push_pipe[1]} + {1'b0, r_push_pipe[2]};
    assign w_used    = {1'b0, w_fifo_count} + {{(c_cw-1){1'b0}}, w_pending};
    assign rdy_o     = (w_used < c_depth);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_group_open <= 1'b0;
            r_grp_sgn    <= 1'b0;
            r_grp_sat    <= 1'b0;
            r_err        <= 1'b0;
            r_push_pipe  <= '0;
            r_sgn_pipe   <= '0;
            r_sat_pipe   <= '0;
        end else begin
            r_push_pipe <= {r_push_pipe[1:0], w_beat_vld & w_last};
            r_sgn_pipe  <= {r_sgn_pipe[1:0], w_beat_sgn};
            r_sat_pipe  <= {r_sat_pipe[1:0], w_beat_sat};
            if (w_accept) begin
                if (w_first) begin
                    if (r_group_open)
                        r_err <= 1'b1;
                    r_group_open <= ~w_last;
                    r_grp_sgn    <= signed_en;
                    r_grp_sat    <= sat_en;
                end else if (!r_group_open) begin
                    r_err <= 1'b1;
                end else if (w_last) begin
                    r_group_open <= 1'b0;
                end
            end
        end
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [CONV_W-1:0] w_ext;
        logic [CONV_W-1:0] w_conv;
        logic              w_unused_conv;

        pe_chan_mac #(
            .LANES (LANES),
            .DW    (DW),
            .ACC_W (ACC_W)
        ) u_mac (
            .clk      (clk),
            .rst_n    (rst_n),
            .i_vld    (w_beat_vld),
            .i_first  (w_first),
            .i_sgn    (w_beat_sgn),
            .i_neuron (neuron),
            .i_weight (weight[c*LANES*DW +: LANES*DW]),
            .o_acc    (w_acc[c])
        );

        assign w_ext  = {{(CONV_W-c_aiw){r_sgn_pipe[2] & w_acc[c][c_aiw-1]}}, w_acc[c]};
        assign w_conv = sat_trunc(w_ext, ACC_W, r_sgn_pipe[2], r_sat_pipe[2]);
        assign w_fifo_din[c*ACC_W +: ACC_W] = w_conv[ACC_W-1:0];
        assign w_unused_conv = ^w_conv[CONV_W-1:ACC_W];
    end

    sync_fifo #(
        .WIDTH (CH*ACC_W),
        .DEPTH (OUT_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (r_push_pipe[2]),
        .i_din   (w_fifo_din),
        .i_pop   (rdy_i),
        .o_dout  (result),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count)
    );

    assign vld_o = ~w_fifo_empty;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_pe_array_mc.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_array_mc
// Brief    : Directed self-checking bench for pe_array_mc.
// Revision : 1.0
// ============================================================================
module tb_pe_array_mc;

    localparam int LANES     = 32;
    localparam int DW        = 16;
    localparam int ACC_W     = 32;
    localparam int CH        = 4;
    localparam int OUT_DEPTH = 4;

    logic                    clk = 1'b0;
    logic                    rst_n = 1'b0;
    logic [LANES*DW-1:0]     neuron = '0;
    logic [CH*LANES*DW-1:0]  weight = '0;
    logic [1:0]              ctl = '0;
    logic                    signed_en = 1'b0;
    logic                    sat_en = 1'b0;
    logic                    vld_i = 1'b0;
    logic                    rdy_o;
    logic [CH*ACC_W-1:0]     result;
    logic                    vld_o;
    logic                    rdy_i = 1'b0;
    logic                    err;

    int checks = 0;
    int errors = 0;

    pe_array_mc #(
        .LANES     (LANES),
        .DW        (DW),
        .ACC_W     (ACC_W),
        .CH        (CH),
        .OUT_DEPTH (OUT_DEPTH)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .neuron    (neuron),
        .weight    (weight),
        .ctl       (ctl),
        .signed_en (signed_en),
        .sat_en    (sat_en),
        .vld_i     (vld_i),
        .rdy_o     (rdy_o),
        .result    (result),
        .vld_o     (vld_o),
        .rdy_i     (rdy_i),
        .err       (err)
    );

    always #5 clk = ~clk;

    function automatic logic [ACC_W-1:0] res(input int c);
        return result[c*ACC_W +: ACC_W];
    endfunction

    task automatic set_beat(input logic [1:0] c, input logic [15:0] n,
                            input logic [15:0] w0, input logic [15:0] w1,
                            input logic [15:0] w2, input logic [15:0] w3,
                            input logic sg, input logic st);
        for (int i = 0; i < LANES; i++) begin
            neuron[i*DW +: DW]             = n;
            weight[(0*LANES+i)*DW +: DW]   = w0;
            weight[(1*LANES+i)*DW +: DW]   = w1;
            weight[(2*LANES+i)*DW +: DW]   = w2;
            weight[(3*LANES+i)*DW +: DW]   = w3;
        end
        ctl       = c;
        signed_en = sg;
        sat_en    = st;
        vld_i     = 1'b1;
    endtask

    task automatic beat(input logic [1:0] c, input logic [15:0] n,
                        input logic [15:0] w0, input logic [15:0] w1,
                        input logic [15:0] w2, input logic [15:0] w3,
                        input logic sg, input logic st);
        set_beat(c, n, w0, w1, w2, w3, sg, st);
        @(posedge clk); #1;
        vld_i = 1'b0;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wait_vld(input int max, input string nm);
        int n;
        n = 0;
        while (!vld_o && n < max) begin
            @(posedge clk); #1;
            n++;
        end
        checks++;
        if (vld_o !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: vld_o=%0b required=1", nm, vld_o);
        end
    endtask

    task automatic pop();
        rdy_i = 1'b1;
        @(posedge clk); #1;
        rdy_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cycles(2);
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL reset_vld_o: got %0b want 0", vld_o); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", err); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %h want 0", result); end
        rst_n = 1'b1;
        cycles(1);
        checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL reset_rdy_o: got %0b want 1", rdy_o); end
    endtask

    task automatic test_unsigned_single();
        beat(2'b11, 16'd1, 16'd2, 16'd3, 16'd4, 16'd0, 1'b0, 1'b0);
        cycles(2);
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL uns_early_vld: got %0b want 0", vld_o); end
        cycles(1);
        checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL uns_latency_vld: got %0b want 1", vld_o); end
        checks++; if (res(0) !== 32'd64) begin errors++; $display("FAIL uns_ch0: got %0d want 64", res(0)); end
        checks++; if (res(1) !== 32'd96) begin errors++; $display("FAIL uns_ch1: got %0d want 96", res(1)); end
        checks++; if (res(2) !== 32'd128) begin errors++; $display("FAIL uns_ch2: got %0d want 128", res(2)); end
        checks++; if (res(3) !== 32'd0) begin errors++; $display("FAIL uns_ch3: got %0d want 0", res(3)); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL uns_err: got %0b want 0", err); end
        pop();
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL uns_pop_vld: got %0b want 0", vld_o); end
        checks++; if (res(0) !== 32'd64) begin errors++; $display("FAIL uns_hold: got %0d want 64", res(0)); end
    endtask

    task automatic test_signed_modes();
        // Mode flips on later beats must be ignored.
        beat(2'b01, 16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 1'b0);
        beat(2'b00, 16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd5, 1'b0, 1'b1);
        beat(2'b10, 16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd5, 1'b0, 1'b1);
        wait_vld(10, "sgn");
        checks++; if (res(0) !== 32'hFFFFFE20) begin errors++; $display("FAIL sgn_ch0: got %h want fffffe20", res(0)); end
        checks++; if (res(3) !== 32'hFFFFFE20) begin errors++; $display("FAIL sgn_ch3: got %h want fffffe20", res(3)); end
        pop();
        beat(2'b01, 16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd5, 1'b0, 1'b0);
        beat(2'b00, 16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 1'b1);
        beat(2'b10, 16'hFFFF, 16'd5, 16'd5, 16'd5, 16'd5, 1'b1, 1'b1);
        wait_vld(10, "usg");
        checks++; if (res(0) !== 32'h01DFFE20) begin errors++; $display("FAIL usg_ch0: got %h want 01dffe20", res(0)); end
        checks++; if (res(2) !== 32'h01DFFE20) begin errors++; $display("FAIL usg_ch2: got %h want 01dffe20", res(2)); end
        pop();
    endtask

    task automatic test_saturation();
        for (int s = 1; s >= 0; s--) begin
            for (int b = 0; b < 8; b++)
                beat((b == 0) ? 2'b01 : ((b == 7) ? 2'b10 : 2'b00),
                     16'h7FFF, 16'h7FFF, 16'h8001, 16'h0000, 16'h7FFF, 1'b1, s[0]);
            wait_vld(10, "sat");
            if (s == 1) begin
                checks++; if (res(0) !== 32'h7FFFFFFF) begin errors++; $display("FAIL sat_pos: got %h want 7fffffff", res(0)); end
                checks++; if (res(1) !== 32'h80000000) begin errors++; $display("FAIL sat_neg: got %h want 80000000", res(1)); end
                checks++; if (res(2) !== 32'h0) begin errors++; $display("FAIL sat_zero: got %h want 0", res(2)); end
            end else begin
                checks++; if (res(0) !== 32'hFF000100) begin errors++; $display("FAIL wrap_pos: got %h want ff000100", res(0)); end
                checks++; if (res(1) !== 32'h00FFFF00) begin errors++; $display("FAIL wrap_neg: got %h want 00ffff00", res(1)); end
                checks++; if (res(3) !== 32'hFF000100) begin errors++; $display("FAIL wrap_ch3: got %h want ff000100", res(3)); end
            end
            pop();
        end
        beat(2'b01, 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 16'd0, 1'b0, 1'b1);
        beat(2'b10, 16'hFFFF, 16'hFFFF, 16'd1, 16'd0, 16'd0, 1'b1, 1'b0);
        wait_vld(10, "usat");
        checks++; if (res(0) !== 32'hFFFFFFFF) begin errors++; $display("FAIL usat_ch0: got %h want ffffffff", res(0)); end
        checks++; if (res(1) !== 32'h003FFFC0) begin errors++; $display("FAIL usat_ch1: got %h want 003fffc0", res(1)); end
        pop();
    endtask

    task automatic test_back_to_back();
        int sent;
        int got;
        int cyc;
        sent = 0;
        cyc  = 0;
        rdy_i = 1'b0;
        while (rdy_o && sent < 6 && cyc < 12) begin
            beat(2'b11, 16'd1, 16'(sent + 1), 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
            sent++;
            cyc++;
        end
        checks++; if (sent != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", sent); end
        cycles(6);
        checks++; if (rdy_o !== 1'b0) begin errors++; $display("FAIL bp_rdy_low: got %0b want 0", rdy_o); end
        checks++; if (vld_o !== 1'b1) begin errors++; $display("FAIL bp_vld: got %0b want 1", vld_o); end
        got = 0;
        cyc = 0;
        rdy_i = 1'b1;
        while (got < 6 && cyc < 60) begin
            if (vld_o) begin
                checks++;
                if (res(0) !== 32'(32 * (got + 1))) begin
                    errors++;
                    $display("FAIL bp_order%0d: got %0d want %0d", got, res(0), 32 * (got + 1));
                end
                got++;
            end
            if (rdy_o && sent < 6) begin
                set_beat(2'b11, 16'd1, 16'(sent + 1), 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
                sent++;
            end else begin
                vld_i = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        vld_i = 1'b0;
        rdy_i = 1'b0;
        checks++; if (got != 6) begin errors++; $display("FAIL bp_drained: got %0d want 6", got); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL bp_err: got %0b want 0", err); end
    endtask

    task automatic test_protocol_err();
        beat(2'b10, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_orphan_err: got %0b want 1", err); end
        cycles(6);
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL perr_no_result: got %0b want 0", vld_o); end
        beat(2'b01, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        beat(2'b00, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        beat(2'b01, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        beat(2'b10, 16'd1, 16'd1, 16'd1, 16'd1, 16'd1, 1'b0, 1'b0);
        wait_vld(10, "perr");
        checks++; if (res(0) !== 32'd64) begin errors++; $display("FAIL perr_restart: got %0d want 64", res(0)); end
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL perr_sticky: got %0b want 1", err); end
        pop();
        cycles(5);
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL perr_single_result: got %0b want 0", vld_o); end
    endtask

    task automatic test_reset_mid();
        rdy_i = 1'b0;
        beat(2'b11, 16'd1, 16'd1, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        beat(2'b11, 16'd1, 16'd2, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        cycles(5);
        beat(2'b11, 16'd1, 16'd3, 16'd0, 16'd0, 16'd0, 1'b0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL rmid_vld: got %0b want 0", vld_o); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL rmid_err: got %0b want 0", err); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        cycles(1);
        checks++; if (rdy_o !== 1'b1) begin errors++; $display("FAIL rmid_rdy: got %0b want 1", rdy_o); end
        cycles(6);
        checks++; if (vld_o !== 1'b0) begin errors++; $display("FAIL rmid_flushed: got %0b want 0", vld_o); end
        beat(2'b01, 16'd2, 16'd3, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0);
        beat(2'b10, 16'd2, 16'd3, 16'd7, 16'd0, 16'd0, 1'b0, 1'b0);
        wait_vld(10, "rmid");
        checks++; if (res(0) !== 32'd384) begin errors++; $display("FAIL rmid_ch0: got %0d want 384", res(0)); end
        checks++; if (res(1) !== 32'd896) begin errors++; $display("FAIL rmid_ch1: got %0d want 896", res(1)); end
        pop();
    endtask

    initial begin
        test_reset();
        test_unsigned_single();
        test_signed_modes();
        test_saturation();
        test_back_to_back();
        test_protocol_err();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
